txt_rom_arbiter: RTL and testbench
==================================

Name: txt_rom_arbiter

Overview:
- Shares one text-ROM lookup path between N_REQ on-screen text-drawing requesters (menu title, score box, player labels, etc.).
- Each text ROM maps an 8-bit char_xy (row/col nibbles) to a 7-bit char code with a registered read.
- This block arbitrates requests round-robin, drives a bank select and char_xy to the text-ROM mux, and routes the returned code back tagged with the requester id.
- It sits between the draw-layer text engines and the bank of text ROMs.

Parameters:
N_REQ, 4, number of requesters (2..8)
XY_W, 8, char_xy width
CODE_W, 7, char_code width
LAT, 1, ROM read latency in cycles from rom_xy valid to rom_code valid (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hold  in  1  freeze new grants (bank reload, blanking); in-flight reads still complete
req  in  N_REQ  per-requester request; held with req_xy stable until granted
req_xy  in  N_REQ*XY_W  per-requester char_xy, requester i at bits [i*XY_W +: XY_W]
gnt  out  N_REQ  one-hot, one-cycle grant pulse
rom_sel  out  $clog2(N_REQ)  text-ROM bank select, equals granted id
rom_xy  out  XY_W  char_xy presented to selected ROM
rom_code  in  CODE_W  code returned by ROM mux, valid LAT cycles after rom_xy
rsp_valid  out  1  response strobe
rsp_id  out  $clog2(N_REQ)  requester owning the response
rsp_code  out  CODE_W  returned char code
busy  out  1  high while any read is in flight or a grant is issued this cycle

Behaviour:
- Reset (synchronous, any cycle incl. mid-operation): gnt=0, rom_sel=0, rom_xy=0, rsp_valid=0, rsp_id=0, rsp_code=0, busy=0, rr pointer=0, all in-flight tags cleared (their responses are dropped, never emitted).
- Arbitration, each clock edge with !rst && !hold && |req: winner = first set req bit scanning from pointer upward, modulo N_REQ. Registered outputs next cycle: gnt=onehot(winner), rom_sel=winner, rom_xy=req_xy[winner]; pointer <= winner+1 (wraps N_REQ-1 -> 0).
- No request or hold=1: gnt=0 next cycle; rom_sel/rom_xy hold last values; pointer unchanged.
- Throughput: one grant per cycle max, fully pipelined; back-to-back grants to different or same requester allowed.
- Requester contract: request consumed in the cycle gnt[i]=1. Requester must deassert req or present the next xy in that same cycle; req still high on the next arbitration edge is a new request.
- Tag pipeline: valid+id shift register of depth LAT+1, loaded in the grant cycle. rsp_valid/rsp_id/rsp_code are registered: rsp_code <= rom_code sampled LAT cycles after the grant cycle. rsp_valid is high exactly LAT+1 cycles after the gnt pulse (LAT=1: gnt cycle k -> rsp cycle k+2).
- Responses return in grant order. rsp_valid is a single-cycle pulse per grant; no backpressure on responses.
- hold asserted mid-stream: no new gnt from the next edge; all outstanding responses still emitted; busy falls the cycle after the last rsp_valid.
- busy = any tag valid OR gnt nonzero.
- Single requester continuous req: granted every cycle (pointer wrap must not starve it).

Test Plan:
- Reset then req=4'b1111 held, all xy distinct -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; rsp_id 0,1,2,3,0 starting 2 cycles after first gnt (LAT=1).
- req=4'b0100 only, req_xy[2]=8'h0b, ROM model returns "b" -> gnt=0100 at cycle k, rom_sel=2, rom_xy=8'h0b at k, rsp_valid=1, rsp_id=2, rsp_code=7'h62 at k+2.
- Pointer wrap: after grant to 3, req=4'b1001 -> next grant 0, then 3 -> alternating, no starvation.
- hold=1 with req=4'b0011 for 5 cycles -> gnt=0 throughout, rom_xy unchanged. hold drops -> gnt=0001 the next cycle.
- Grant at cycle k, rst at k+1 -> no rsp_valid at k+2. All outputs 0 and pointer=0 after reset; first post-reset grant goes to requester 0 given req=1111.
- LAT=3 build, 3 back-to-back grants -> 3 rsp_valid pulses at gnt+4, ids and codes in grant order; busy deasserts one cycle after the last pulse.

Source files
------------

// File: rtl/txt_rom_arbiter.sv
// Round-robin arbiter sharing one text-ROM lookup path between N_REQ text engines.
// Returned char codes are tagged with the requester id and emitted in grant order.
module txt_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int XY_W   = 8,
    parameter int CODE_W = 7,
    parameter int LAT    = 1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hold,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*XY_W-1:0] i_req_xy,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [ID_W-1:0]       o_rom_sel,
    output logic [XY_W-1:0]       o_rom_xy,
    input  logic [CODE_W-1:0]     i_rom_code,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [CODE_W-1:0]     o_rsp_code,
    output logic                  o_busy
);

    localparam logic [ID_W:0]   NREQ_EXT = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]   r_ptr;
    logic [N_REQ-1:0]  r_gnt;
    logic [ID_W-1:0]   r_sel;
    logic [XY_W-1:0]   r_xy;
    logic [LAT:0]      r_tag_v;
    logic [ID_W-1:0]   r_tag_id [0:LAT];
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [CODE_W-1:0] r_rsp_code;

    logic [N_REQ-1:0]  w_rot;
    logic [ID_W-1:0]   w_off;
    logic [ID_W:0]     w_sum;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [XY_W-1:0]   w_xy;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_fire;

    // Rotate requests so that bit 0 is the requester the pointer currently favours.
    always_comb begin
        w_rot = '0;
        for (int s = 0; s < N_REQ; s++) begin
            if (r_ptr == ID_W'(s)) begin
                for (int i = 0; i < N_REQ; i++) begin
                    w_rot[i] = i_req[(i + s) % N_REQ];
                end
            end
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_fire    = !i_hold && (|i_req);
        w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
        w_winner  = (w_sum >= NREQ_EXT) ? ID_W'(w_sum - NREQ_EXT) : w_sum[ID_W-1:0];
        w_ptr_nxt = (w_winner == LAST_ID) ? '0 : w_winner + ID_W'(1);
    end

    always_comb begin
        w_xy     = '0;
        w_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_xy        = i_req_xy[i*XY_W +: XY_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_xy        <= '0;
            r_tag_v     <= '0;
            for (int j = 0; j <= LAT; j++) begin
                r_tag_id[j] <= '0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_code  <= '0;
        end else begin
            r_gnt <= '0;
            if (w_fire) begin
                r_gnt <= w_onehot;
                r_sel <= w_winner;
                r_xy  <= w_xy;
                r_ptr <= w_ptr_nxt;
            end
            // Stage 0 is the grant cycle; stage LAT lines up with the ROM's returned code.
            r_tag_v     <= {r_tag_v[LAT-1:0], w_fire};
            r_tag_id[0] <= w_winner;
            for (int j = 1; j <= LAT; j++) begin
                r_tag_id[j] <= r_tag_id[j-1];
            end
            r_rsp_valid <= r_tag_v[LAT];
            if (r_tag_v[LAT]) begin
                r_rsp_id   <= r_tag_id[LAT];
                r_rsp_code <= i_rom_code;
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rom_sel   = r_sel;
    assign o_rom_xy    = r_xy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_code  = r_rsp_code;
    // The response register counts as the final tag stage so busy covers the rsp pulse.
    assign o_busy      = (|r_tag_v) || (|r_gnt) || r_rsp_valid;

endmodule

// File: tb/tb_txt_rom_arbiter.sv
// Scoreboard bench for txt_rom_arbiter: LAT=1 and LAT=3 instances share stimulus,
// a behavioural round-robin model predicts grants and tagged responses.
module tb_txt_rom_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [31:0] req_xy;

    logic [3:0] gnt1, gnt3;
    logic [1:0] sel1, sel3, rid1, rid3;
    logic [7:0] xy1, xy3;
    logic [6:0] code1, code3, rc1, rc3;
    logic       rv1, rv3, busy1, busy3;

    always #5 clk = ~clk;

    txt_rom_arbiter #(.N_REQ(4), .XY_W(8), .CODE_W(7), .LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_req(req), .i_req_xy(req_xy),
        .o_gnt(gnt1), .o_rom_sel(sel1), .o_rom_xy(xy1), .i_rom_code(code1),
        .o_rsp_valid(rv1), .o_rsp_id(rid1), .o_rsp_code(rc1), .o_busy(busy1)
    );

    txt_rom_arbiter #(.N_REQ(4), .XY_W(8), .CODE_W(7), .LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_req(req), .i_req_xy(req_xy),
        .o_gnt(gnt3), .o_rom_sel(sel3), .o_rom_xy(xy3), .i_rom_code(code3),
        .o_rsp_valid(rv3), .o_rsp_id(rid3), .o_rsp_code(rc3), .o_busy(busy3)
    );

    function automatic logic [6:0] rom_fn(input logic [7:0] xy);
        return 7'(xy + 8'h57);
    endfunction

    // Text-ROM models with registered reads of latency 1 and 3.
    logic [6:0] rom1_q;
    logic [6:0] rom3_q [3];
    always @(posedge clk) begin
        rom1_q    <= rom_fn(xy1);
        rom3_q[0] <= rom_fn(xy3);
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign code1 = rom1_q;
    assign code3 = rom3_q[2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    typedef struct {
        int         due;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] xy;
        bit         rst;
    } gexp_t;

    typedef struct {
        int         due;
        int         g;
        int         kill;
        logic [1:0] id;
        logic [6:0] code;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq1[$], rq3[$];

    int         m_ptr  = 0;
    logic [1:0] m_sel  = '0;
    logic [7:0] m_xy   = '0;

    // Apply inputs for the next edge and record what the spec says must follow.
    task automatic step(input bit r, input bit h, input logic [3:0] rq, input logic [31:0] xys);
        gexp_t ge;
        rexp_t re;
        int    w;
        rst = r; hold = h; req = rq; req_xy = xys;
        ge.due = cyc + 1;
        ge.rst = r;
        ge.gnt = '0;
        if (r) begin
            m_ptr = 0; m_sel = '0; m_xy = '0;
            foreach (rq1[j]) if (rq1[j].due >= cyc + 1) rq1[j].kill = cyc + 1;
            foreach (rq3[j]) if (rq3[j].due >= cyc + 1) rq3[j].kill = cyc + 1;
        end else if (!h && rq != 4'b0) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && ((rq >> ((m_ptr + i) % N)) & 4'd1) != 4'd0) w = (m_ptr + i) % N;
            end
            m_sel  = 2'(w);
            m_xy   = 8'(xys >> (w * 8));
            m_ptr  = (w + 1) % N;
            ge.gnt = 4'(1 << w);
            re.g    = cyc + 1;
            re.kill = 32'h7fffffff;
            re.id   = 2'(w);
            re.code = rom_fn(m_xy);
            re.due  = cyc + 3;
            rq1.push_back(re);
            re.due  = cyc + 5;
            rq3.push_back(re);
        end
        ge.sel = m_sel;
        ge.xy  = m_xy;
        gq.push_back(ge);
        @(posedge clk);
        #1;
    endtask

    gexp_t mg;
    always @(negedge clk) begin
        if (gq.size() > 0 && gq[0].due == cyc) begin
            mg = gq.pop_front();
            chk("gnt_lat1", gnt1, mg.gnt);
            chk("gnt_lat3", gnt3, mg.gnt);
            chk("rom_sel_lat1", sel1, mg.sel);
            chk("rom_sel_lat3", sel3, mg.sel);
            chk("rom_xy_lat1", xy1, mg.xy);
            chk("rom_xy_lat3", xy3, mg.xy);
            if (mg.rst) begin
                chk("rst_rsp_lat1", {rv1, rid1, rc1, busy1}, 0);
                chk("rst_rsp_lat3", {rv3, rid3, rc3, busy3}, 0);
            end
        end
    end

    rexp_t r1, r3;
    rexp_t t1[$], t3[$];
    bit    b1, b3;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            t1 = {};
            foreach (rq1[j]) if (rq1[j].kill > cyc) t1.push_back(rq1[j]);
            rq1 = t1;
            b1 = 1'b0;
            foreach (rq1[j]) if (rq1[j].g <= cyc) b1 = 1'b1;
            chk("busy_lat1", busy1, b1);
            if (rv1) begin
                if (rq1.size() > 0 && rq1[0].due == cyc) begin
                    r1 = rq1.pop_front();
                    chk("rsp_id_lat1", rid1, r1.id);
                    chk("rsp_code_lat1", rc1, r1.code);
                end else begin
                    chk("rsp_unexpected_lat1", rv1, 0);
                end
            end else if (rq1.size() > 0 && rq1[0].due == cyc) begin
                chk("rsp_missing_lat1", rv1, 1);
                void'(rq1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            t3 = {};
            foreach (rq3[j]) if (rq3[j].kill > cyc) t3.push_back(rq3[j]);
            rq3 = t3;
            b3 = 1'b0;
            foreach (rq3[j]) if (rq3[j].g <= cyc) b3 = 1'b1;
            chk("busy_lat3", busy3, b3);
            if (rv3) begin
                if (rq3.size() > 0 && rq3[0].due == cyc) begin
                    r3 = rq3.pop_front();
                    chk("rsp_id_lat3", rid3, r3.id);
                    chk("rsp_code_lat3", rc3, r3.code);
                end else begin
                    chk("rsp_unexpected_lat3", rv3, 0);
                end
            end else if (rq3.size() > 0 && rq3[0].due == cyc) begin
                chk("rsp_missing_lat3", rv3, 1);
                void'(rq3.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] xy_all;
        xy_all = 32'h44332211;
        step(1, 0, 4'b0000, '0);
        step(1, 0, 4'b0000, '0);
        // All four requesting: rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) step(0, 0, 4'b1111, xy_all);
        step(0, 0, 4'b0000, xy_all);
        // Single requester 2 looking up 0x0b.
        step(0, 0, 4'b0100, 32'h000b0000);
        for (int i = 0; i < 4; i++) step(0, 0, 4'b0000, 32'h000b0000);
        // Pointer wrap: 3, then alternate 0/3.
        step(0, 0, 4'b1000, xy_all);
        for (int i = 0; i < 6; i++) step(0, 0, 4'b1001, xy_all + 32'(i));
        // Hold freezes grants and rom_xy.
        for (int i = 0; i < 5; i++) step(0, 1, 4'b0011, 32'h0000a5b6);
        step(0, 0, 4'b0011, 32'h0000a5b6);
        step(0, 0, 4'b0000, '0);
        // Grant then immediate reset drops the in-flight response.
        step(0, 0, 4'b0010, 32'h00007700);
        step(1, 0, 4'b1111, xy_all);
        step(0, 0, 4'b1111, xy_all);
        // Continuous single requester must be granted every cycle.
        for (int i = 0; i < 6; i++) step(0, 0, 4'b0100, 32'(i) << 16);
        // Hold mid-stream: outstanding responses still complete.
        for (int i = 0; i < 3; i++) step(0, 0, 4'b1111, xy_all ^ 32'(i));
        for (int i = 0; i < 7; i++) step(0, 1, 4'b1111, xy_all);
        // Randomized traffic with occasional hold and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom),
                 $urandom);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 4'b0000, '0);
        @(negedge clk);
        #1;
        chk("grant_queue_drained", gq.size(), 0);
        chk("rsp_queue_drained_lat1", rq1.size(), 0);
        chk("rsp_queue_drained_lat3", rq3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
